// File: rtl/freelist_pkg.sv
// Shared rename defines: register-file sizing and freelist pointer geometry.
`ifndef FREELIST_PKG_SV
`define FREELIST_PKG_SV
`define PREG_RANGE 5:0

package freelist_pkg;
  localparam int FL_PREG_NUM = 64;
  localparam int FL_LREG_NUM = 32;
  localparam int FL_DEPTH    = FL_PREG_NUM - FL_LREG_NUM;
  localparam int FL_IDX_W    = $clog2(FL_DEPTH);
  localparam int FL_PTR_W    = FL_IDX_W + 1;
endpackage

`endif

// File: rtl/freelist.sv
// Physical-register freelist: circular buffer with speculative/architectural heads,
// two-wide allocate at rename and two-wide release at commit, flush rewinds to arch head.
module freelist
  import freelist_pkg::*;
#(
  parameter int PREG_NUM = FL_PREG_NUM,
  parameter int LREG_NUM = FL_LREG_NUM
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               instr0_freelist_req,
  input  logic               instr1_freelist_req,
  input  logic               rename_fire,
  output logic [`PREG_RANGE] instr0_freelist_resp,
  output logic [`PREG_RANGE] instr1_freelist_resp,
  output logic               freelist_can_alloc,
  input  logic               commit0_free_valid,
  input  logic               commit1_free_valid,
  input  logic [`PREG_RANGE] commit0_free_preg,
  input  logic [`PREG_RANGE] commit1_free_preg,
  input  logic               commit0_alloc_valid,
  input  logic               commit1_alloc_valid,
  input  logic               flush_valid,
  output logic [5:0]         freelist_count
);
  localparam int DEPTH = PREG_NUM - LREG_NUM;
  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = IW + 1;

  logic [DEPTH-1:0][5:0] r_entry;
  logic [PW-1:0]         r_spec_head, r_arch_head, r_tail;

  logic [PW-1:0] w_count, w_spec1, w_tail1, w_arch_nxt, w_spec_nxt, w_tail_nxt;
  logic [1:0]    w_pop_n;

  always_comb begin
    w_count    = r_tail - r_spec_head;
    w_spec1    = r_spec_head + PW'(instr0_freelist_req);
    w_pop_n    = 2'd0;
    if (rename_fire && freelist_can_alloc && !flush_valid)
      w_pop_n = {1'b0, instr0_freelist_req} + {1'b0, instr1_freelist_req};
    w_arch_nxt = r_arch_head + PW'(commit0_alloc_valid) + PW'(commit1_alloc_valid);
    // Flush rewinds to the arch head including this cycle's commits.
    w_spec_nxt = flush_valid ? w_arch_nxt : r_spec_head + PW'(w_pop_n);
    w_tail1    = r_tail + PW'(commit0_free_valid);
    w_tail_nxt = w_tail1 + PW'(commit1_free_valid);
  end

  assign freelist_count       = 6'(w_count);
  assign freelist_can_alloc   = (w_count >= PW'(2));
  assign instr0_freelist_resp = r_entry[r_spec_head[IW-1:0]];
  assign instr1_freelist_resp = r_entry[w_spec1[IW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= 6'(LREG_NUM + i);
      r_spec_head <= '0;
      r_arch_head <= '0;
      r_tail      <= PW'(DEPTH);
    end else begin
      if (commit0_free_valid) r_entry[r_tail[IW-1:0]]  <= commit0_free_preg;
      if (commit1_free_valid) r_entry[w_tail1[IW-1:0]] <= commit1_free_preg;
      r_spec_head <= w_spec_nxt;
      r_arch_head <= w_arch_nxt;
      r_tail      <= w_tail_nxt;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    (32'(w_count) + 32'(commit0_free_valid) + 32'(commit1_free_valid)) <= DEPTH);
  a_no_preg0_free0: assert property (@(posedge clock) disable iff (!reset_n)
    commit0_free_valid |-> (commit0_free_preg != '0));
  a_no_preg0_free1: assert property (@(posedge clock) disable iff (!reset_n)
    commit1_free_valid |-> (commit1_free_preg != '0));
endmodule

// File: tb/tb_freelist.sv
// Directed bench for freelist plus a short modelled alloc/commit/free run across pointer wrap.
`timescale 1ns/1ps
module tb_freelist;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       req0, req1, fire;
  logic [5:0] resp0, resp1;
  logic       can_alloc;
  logic       f0v, f1v, a0v, a1v, flush;
  logic [5:0] f0p, f1p;
  logic [5:0] count;

  int checks = 0;
  int errors = 0;

  freelist dut (
    .clock(clock), .reset_n(reset_n),
    .instr0_freelist_req(req0), .instr1_freelist_req(req1), .rename_fire(fire),
    .instr0_freelist_resp(resp0), .instr1_freelist_resp(resp1),
    .freelist_can_alloc(can_alloc),
    .commit0_free_valid(f0v), .commit1_free_valid(f1v),
    .commit0_free_preg(f0p), .commit1_free_preg(f1p),
    .commit0_alloc_valid(a0v), .commit1_alloc_valid(a1v),
    .flush_valid(flush), .freelist_count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; fire = 0; f0v = 0; f1v = 0; f0p = 0; f1p = 0;
    a0v = 0; a1v = 0; flush = 0;
  endtask

  // Inputs change on the falling edge; one step crosses exactly one rising edge.
  task automatic step();
    @(negedge clock);
    idle();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    reset_n = 0;
    #1;
    @(negedge clock);
    reset_n = 1;
    #1;
  endtask

  task automatic alloc_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      req0 = 1; req1 = 1; fire = 1;
      step();
    end
  endtask

  logic [5:0] q[$];
  logic [5:0] live[$];
  int unc;

  initial begin
    idle();
    reset_n = 1;
    #2 reset_n = 0;
    #1;
    chk("rst_count", count, 32);
    chk("rst_can", can_alloc, 1);
    chk("rst_resp0", resp0, 32);
    chk("rst_resp1_noreq0", resp1, 32);
    req0 = 1; #1;
    chk("rst_resp1_req0", resp1, 33);
    @(negedge clock); reset_n = 1; idle(); #1;

    // pair allocate from reset
    req0 = 1; req1 = 1; fire = 1; #1;
    chk("pair_resp0", resp0, 32);
    chk("pair_resp1", resp1, 33);
    step();
    chk("pair_next_resp0", resp0, 34);
    chk("pair_count", count, 30);

    // requests without rename_fire consume nothing
    req0 = 1; req1 = 1; fire = 0;
    step();
    chk("nofire_count", count, 30);

    // slot 1 alone
    do_reset();
    req1 = 1; fire = 1; #1;
    chk("s1_resp1", resp1, 32);
    step();
    chk("s1_count", count, 31);
    chk("s1_resp0", resp0, 33);

    // drain to one entry, stall, then a free re-enables allocation
    do_reset();
    alloc_pairs(15);
    req0 = 1; fire = 1;
    step();
    chk("drain_count", count, 1);
    chk("drain_can", can_alloc, 0);
    req0 = 1; req1 = 1; fire = 1; #1;
    chk("stall_resp0", resp0, 63);
    step();
    chk("stall_count", count, 1);
    chk("stall_resp0_hold", resp0, 63);
    f0v = 1; f0p = 6'd5; #1;
    chk("free_same_cycle_can", can_alloc, 0);
    step();
    chk("free_can", can_alloc, 1);
    chk("free_count", count, 2);
    req0 = 1; #1;
    chk("free_resp1", resp1, 5);
    idle();

    // flush rewinds to the arch head including same-cycle commits
    do_reset();
    alloc_pairs(2);
    chk("fl_pre_count", count, 28);
    a0v = 1;
    step();
    flush = 1; a1v = 1; req0 = 1; req1 = 1; fire = 1;
    step();
    chk("fl_count", count, 30);
    chk("fl_resp0", resp0, 34);
    flush = 1; f0v = 1; f0p = 6'd12;
    step();
    chk("fl_push_count", count, 31);
    chk("fl_push_resp0", resp0, 34);

    // simultaneous pop of the last two and free of 7, 9 across the wrap
    do_reset();
    alloc_pairs(15);
    req0 = 1; req1 = 1; fire = 1; f0v = 1; f0p = 6'd7; f1v = 1; f1p = 6'd9; #1;
    chk("pp_resp0", resp0, 62);
    chk("pp_resp1", resp1, 63);
    step();
    chk("pp_count", count, 2);
    chk("pp_wrap_resp0", resp0, 7);
    req0 = 1; #1;
    chk("pp_wrap_resp1", resp1, 9);
    idle();

    // modelled run: 100 cycles of alloc/commit/free
    do_reset();
    q.delete(); live.delete(); unc = 0;
    for (int i = 0; i < 32; i++) q.push_back(6'(32 + i));
    for (int c = 0; c < 100; c++) begin
      logic r0, r1, fi, g0, g1;
      logic [5:0] p0, p1;
      int a, np;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      fi = ($urandom_range(0, 3) != 0);
      g0 = 0; g1 = 0; p0 = 0; p1 = 0;
      if (live.size() > 0 && $urandom_range(0, 2) != 0) begin g0 = 1; p0 = live.pop_front(); end
      if (live.size() > 0 && $urandom_range(0, 2) != 0) begin g1 = 1; p1 = live.pop_front(); end
      a = $urandom_range(0, 2);
      if (a > unc) a = unc;
      req0 = r0; req1 = r1; fire = fi;
      f0v = g0; f0p = p0; f1v = g1; f1p = p1;
      a0v = (a >= 1); a1v = (a >= 2);
      #1;
      chk("run_count", count, q.size());
      chk("run_can", can_alloc, int'(q.size() >= 2));
      np = 0;
      if (q.size() >= 2) begin
        chk("run_resp0", resp0, q[0]);
        chk("run_resp1", resp1, q[r0 ? 1 : 0]);
        if (fi) np = int'(r0) + int'(r1);
      end
      for (int k = 0; k < np; k++) begin
        logic [5:0] p;
        p = q.pop_front();
        for (int j = 0; j < live.size(); j++)
          chk("run_not_live", int'(p == live[j]), 0);
        live.push_back(p);
      end
      unc = unc + np - a;
      if (g0) q.push_back(p0);
      if (g1) q.push_back(p1);
      step();
    end
    chk("run_end_count", count, q.size());
    flush = 1;
    step();
    chk("run_flush_count", count, q.size() + unc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/freelist.md
FREELIST -- requirements
Module: freelist

Interface
REQ-001 Parameter: PREG_NUM, default 64, number of physical registers; `PREG_RANGE` is [5:0].
REQ-002 Parameter: LREG_NUM, default 32, number of architectural registers; freelist depth DEPTH = PREG_NUM-LREG_NUM = 32.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 instr0_freelist_req  in  1  rename slot 0 needs a destination preg.
REQ-007 instr1_freelist_req  in  1  rename slot 1 needs a destination preg.
REQ-008 rename_fire  in  1  rename group accepted downstream this cycle; requests consume entries only when high.
REQ-009 instr0_freelist_resp  out  6  preg offered to slot 0.
REQ-010 instr1_freelist_resp  out  6  preg offered to slot 1.
REQ-011 freelist_can_alloc  out  1  at least 2 free entries; rename stalls when low.
REQ-012 commit0_free_valid, commit1_free_valid  in  1 each  committed instr releases its old_prd.
REQ-013 commit0_free_preg, commit1_free_preg  in  6 each  preg being released.
REQ-014 commit0_alloc_valid, commit1_alloc_valid  in  1 each  committed instr had allocated a prd.
REQ-015 flush_valid  in  1  pipeline redirect; all speculative allocations are returned.
REQ-016 freelist_count  out  6  current number of free entries (0..32).

Function
REQ-017 Storage: circular buffer of DEPTH 6-bit entries; spec_head, arch_head, tail pointers each 6 bits (5-bit index + wrap bit).
REQ-018 count = tail - spec_head (6-bit modular); freelist_count = count; freelist_can_alloc = (count >= 2).
REQ-019 instr0_freelist_resp = entry[spec_head]; instr1_freelist_resp = entry[spec_head + instr0_freelist_req]; both combinational, zero latency.
REQ-020 Pop: when rename_fire & freelist_can_alloc & ~flush_valid, spec_head advances by instr0_freelist_req + instr1_freelist_req (0, 1 or 2) at the next edge.
REQ-021 rename_fire with freelist_can_alloc low consumes nothing.
REQ-022 Push: each commitN_free_valid writes its preg at tail; order slot 0 then slot 1; tail advances by the number of valid frees (0..2).
REQ-023 Commit: arch_head advances by commit0_alloc_valid + commit1_alloc_valid each cycle.
REQ-024 Flush: spec_head <= arch_head value after this cycle's REQ-023 update; pops that cycle are suppressed; pushes that cycle still occur.
REQ-025 Simultaneous push and pop: pop uses pre-edge count; a preg freed in cycle N is allocatable no earlier than cycle N+1.
REQ-026 Pointer wrap: index wraps 31->0 and wrap bit toggles; count correct across wrap.
REQ-027 Frees that would make count exceed DEPTH are illegal; assertion fires; RTL behaviour is unspecified.
REQ-028 Preg 0 is never allocated: it is never placed in the list at reset and is never pushed by commit.

Reset
REQ-029 On reset_n low (asynchronous): entry[i] = 32+i for i=0..31; spec_head = arch_head = 6'b000000; tail = 6'b100000 (count = 32).
REQ-030 Outputs after reset: instr0_freelist_resp = 32; instr1_freelist_resp = 32 if instr0 req low, else 33; freelist_can_alloc = 1; freelist_count = 32.
REQ-031 Reset asserted mid-operation discards all pending pops and pushes and restores REQ-029 state.

Structure
REQ-032 PREG_NUM, LREG_NUM, DEPTH and the pointer width belong in the shared defines package alongside `PREG_RANGE`.
REQ-033 Single flat module; no sub-module; storage is a flop array (2 read, 2 write ports).

Verification
REQ-034 Reset, both req high, rename_fire -> resp0=32, resp1=33; next cycle resp0=34, count=30.
REQ-035 Only instr1 req with rename_fire -> resp1=32, spec_head +1, count=31.
REQ-036 Allocate 31 entries, then request 2 -> freelist_can_alloc=0, count=1, head unchanged; free preg 5 -> next cycle can_alloc=1.
REQ-037 Allocate 4 (32..35), commit 2 allocs, then flush -> spec_head = arch_head, count=30, resp0=34.
REQ-038 Same cycle: pop 2, free pregs 7 and 9 -> count unchanged net; 7 then 9 appear at tail; neither is returned that cycle.
REQ-039 Run 100 alloc/commit/free cycles -> pointers wrap past 31, count stays consistent, no preg is handed out twice while live.
